i2c_slave_bus_engine: RTL

//   Bit/byte-level I2C slave front end; feeds the register-file block (addr/dataIn/writeEn/dataOut).

---
 rtl/i2c_slave_bus_engine.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_bus_engine.sv
// i2c_slave_bus_engine: I2C slave bit/byte engine feeding a register file.
// Samples raw SCL/SDA, detects START/STOP, matches DEV_ADDR, keeps an
// auto-incrementing register pointer, emits write strobes, shifts out reads.
// Optional SCL-stuck-low timeout is enabled by defining I2C_TIMEOUT_EN.
module i2c_slave_bus_engine #(
  parameter logic [6:0]  DEV_ADDR       = 7'h3C,
  parameter int unsigned FILTER_DEPTH   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [2:0] FILT_MAX = 3'(FILTER_DEPTH - 1);

  if (FILTER_DEPTH < 1 || FILTER_DEPTH > 7 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("i2c_slave_bus_engine: FILTER_DEPTH must be 1..7, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_f;
  logic       r_sda_f;
  logic [2:0] r_scl_cnt;
  logic [2:0] r_sda_cnt;
  logic       r_scl_prev;
  logic       r_sda_prev;

  state_t     r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_nack;
  logic       r_sda_oe;
  logic [7:0] r_reg_addr;
  logic [7:0] r_reg_wdata;
  logic       r_reg_we;
  logic       r_busy;

  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_timeout;
  logic [7:0] w_shift_in;

  // Two-flop synchronizers; idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
    end
  end

  // Glitch filters: a new level is accepted after FILTER_DEPTH equal samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_f   <= 1'b1;
      r_sda_f   <= 1'b1;
      r_scl_cnt <= 3'd0;
      r_sda_cnt <= 3'd0;
    end else begin
      if (r_scl_sync[1] == r_scl_f) begin
        r_scl_cnt <= 3'd0;
      end else if (r_scl_cnt == FILT_MAX) begin
        r_scl_f   <= r_scl_sync[1];
        r_scl_cnt <= 3'd0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 3'd1;
      end
      if (r_sda_sync[1] == r_sda_f) begin
        r_sda_cnt <= 3'd0;
      end else if (r_sda_cnt == FILT_MAX) begin
        r_sda_f   <= r_sda_sync[1];
        r_sda_cnt <= 3'd0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 3'd1;
      end
    end
  end

  // Previous filtered levels for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= r_scl_f;
      r_sda_prev <= r_sda_f;
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_f & r_scl_prev;
  assign w_start    = r_scl_f & r_scl_prev & r_sda_prev & ~r_sda_f;
  assign w_stop     = r_scl_f & r_scl_prev & ~r_sda_prev & r_sda_f;
  assign w_shift_in = {r_shift[6:0], r_sda_f};

`ifdef I2C_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Counts clk cycles with SCL held low during a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (!r_busy || r_scl_f) begin
      r_to_cnt <= '0;
    end else if (!w_timeout) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  // Protocol FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_rw        <= 1'b0;
      r_nack      <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_reg_addr  <= 8'h00;
      r_reg_wdata <= 8'h00;
      r_reg_we    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_reg_we <= 1'b0;
      // pointer advances the clk after a write strobe
      if (r_reg_we) begin
        r_reg_addr <= r_reg_addr + 8'd1;
      end
      if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
      end else if (w_timeout) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_IGNORE: begin
          end
          S_ADDR, S_PTR, S_WR_DATA: begin
            if (w_scl_rise && r_bit_cnt < 4'd8) begin
              r_shift   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                if (r_state == S_PTR) begin
                  r_reg_addr <= w_shift_in;
                end else if (r_state == S_WR_DATA) begin
                  r_reg_wdata <= w_shift_in;
                  r_reg_we    <= 1'b1;
                end
              end
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              if (r_state == S_ADDR) begin
                if (r_shift[7:1] == DEV_ADDR) begin
                  r_state  <= S_ADDR_ACK;
                  r_rw     <= r_shift[0];
                  r_sda_oe <= 1'b1;
                end else begin
                  r_state <= S_IGNORE;
                end
              end else if (r_state == S_PTR) begin
                r_state  <= S_PTR_ACK;
                r_sda_oe <= 1'b1;
              end else begin
                r_state  <= S_WR_ACK;
                r_sda_oe <= 1'b1;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (r_rw) begin
                r_state  <= S_RD_DATA;
                r_shift  <= reg_rdata;
                r_sda_oe <= ~reg_rdata[7];
              end else begin
                r_state  <= S_PTR;
                r_sda_oe <= 1'b0;
              end
            end
          end
          S_PTR_ACK, S_WR_ACK: begin
            if (w_scl_fall) begin
              r_state  <= S_WR_DATA;
              r_sda_oe <= 1'b0;
            end
          end
          S_RD_DATA: begin
            if (w_scl_rise && r_bit_cnt < 4'd8) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt != 4'd0) begin
              if (r_bit_cnt == 4'd8) begin
                r_state    <= S_RD_ACK;
                r_bit_cnt  <= 4'd0;
                r_sda_oe   <= 1'b0;
                r_reg_addr <= r_reg_addr + 8'd1;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) begin
              r_nack <= r_sda_f;
            end else if (w_scl_fall) begin
              if (r_nack) begin
                r_state  <= S_IGNORE;
                r_sda_oe <= 1'b0;
              end else begin
                r_state  <= S_RD_DATA;
                r_shift  <= reg_rdata;
                r_sda_oe <= ~reg_rdata[7];
              end
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;
  assign reg_we    = r_reg_we;
  assign busy      = r_busy;

endmodule
